// File: rtl/lcd_write_controller.sv
// lcd_write_controller: HD44780 single-byte write engine producing a fixed-width enable strobe
module lcd_write_controller #(
  parameter int CLK_DIVIDE = 16
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);
  localparam int CW = $clog2(CLK_DIVIDE) > 5 ? $clog2(CLK_DIVIDE) : 5;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIVIDE - 1);
  typedef enum logic [1:0] {ST0, ST1, ST2, ST3} st_t;
  st_t st;
  logic pre_start;
  logic m_start;
  logic [CW-1:0] cont;
  assign LCD_DATA = iDATA;
  assign LCD_RS = iRS;
  assign LCD_RW = 1'b0;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDone <= 1'b0;
      LCD_EN <= 1'b0;
      pre_start <= 1'b0;
      m_start <= 1'b0;
      cont <= '0;
      st <= ST0;
    end else begin
      pre_start <= iStart;
      if (iStart && !pre_start) begin
        m_start <= 1'b1;
        oDone <= 1'b0;
      end
      if (m_start) begin
        case (st)
          ST0: st <= ST1;
          ST1: begin
            LCD_EN <= 1'b1;
            st <= ST2;
          end
          ST2: begin
            if (cont < CMAX) cont <= cont + 1'b1;
            else st <= ST3;
          end
          ST3: begin
            LCD_EN <= 1'b0;
            m_start <= 1'b0;
            oDone <= 1'b1;
            cont <= '0;
            st <= ST0;
          end
          default: st <= ST0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_write_controller.sv
// tb_lcd_write_controller: directed plus random checks of two divider builds against a timing model
module tb_lcd_write_controller;
  logic iCLK = 1'b0;
  logic iRST;
  logic [7:0] iDATA;
  logic iRS;
  logic iStart;
  logic done_a, en_a, rw_a, rs_a;
  logic done_b, en_b, rw_b, rs_b;
  logic [7:0] data_a, data_b;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv[2] = '{16, 4};
  int e0[2] = '{0, 0};
  bit started[2] = '{0, 0};
  bit prev_start = 1'b0;
  int en_cnt = 0;
  int done_at = -1;
  int rel = 0;
  always #5 iCLK = ~iCLK;
  lcd_write_controller #(.CLK_DIVIDE(16)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
    .oDone(done_a), .LCD_DATA(data_a), .LCD_RW(rw_a), .LCD_EN(en_a), .LCD_RS(rs_a)
  );
  lcd_write_controller #(.CLK_DIVIDE(4)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iRS(iRS), .iStart(iStart),
    .oDone(done_b), .LCD_DATA(data_b), .LCD_RW(rw_b), .LCD_EN(en_b), .LCD_RS(rs_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input logic rst, input logic st, input logic [7:0] d, input logic rs);
    logic exp_en[2];
    logic exp_done[2];
    iRST = rst;
    iStart = st;
    iDATA = d;
    iRS = rs;
    #1;
    chk("data_a", 32'(data_a), 32'(d));
    chk("data_b", 32'(data_b), 32'(d));
    chk("rs_a", 32'(rs_a), 32'(rs));
    chk("rs_b", 32'(rs_b), 32'(rs));
    chk("rw_a", 32'(rw_a), 32'd0);
    chk("rw_b", 32'(rw_b), 32'd0);
    @(posedge iCLK);
    for (int k = 0; k < 2; k++) begin
      if (rst) started[k] = 1'b0;
      else if (st && !prev_start && !(started[k] && cyc - e0[k] <= dv[k] + 3)) begin
        started[k] = 1'b1;
        e0[k] = cyc;
      end
      exp_en[k] = started[k] && cyc - e0[k] >= 2 && cyc - e0[k] <= dv[k] + 2;
      exp_done[k] = started[k] && cyc - e0[k] >= dv[k] + 3;
    end
    prev_start = rst ? 1'b0 : st;
    #1;
    chk("en_a", 32'(en_a), 32'(exp_en[0]));
    chk("done_a", 32'(done_a), 32'(exp_done[0]));
    chk("en_b", 32'(en_b), 32'(exp_en[1]));
    chk("done_b", 32'(done_b), 32'(exp_done[1]));
    if (en_a === 1'b1) en_cnt++;
    if (done_a === 1'b1 && done_at < 0) done_at = rel;
    rel++;
    cyc++;
  endtask
  task automatic measure_start();
    en_cnt = 0;
    done_at = -1;
    rel = 0;
  endtask
  initial begin
    logic s;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    measure_start();
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 8'h38, 1'b0);
    chk("en_width_38", 32'(en_cnt), 32'd17);
    chk("done_lat_38", 32'(done_at), 32'd19);
    step(1'b0, 1'b0, 8'h38, 1'b0);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 8'h57, 1'b1);
    step(1'b0, 1'b0, 8'h57, 1'b1);
    measure_start();
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 8'h45, 1'b1);
    chk("en_width_45", 32'(en_cnt), 32'd17);
    chk("done_lat_45", 32'(done_at), 32'd19);
    step(1'b0, 1'b0, 8'h45, 1'b1);
    step(1'b0, 1'b0, 8'h45, 1'b1);
    measure_start();
    for (int i = 0; i < 28; i++) step(1'b0, i != 5, 8'h01, 1'b0);
    chk("en_width_toggle", 32'(en_cnt), 32'd17);
    chk("done_lat_toggle", 32'(done_at), 32'd19);
    step(1'b0, 1'b0, 8'h01, 1'b0);
    measure_start();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'hC0, 1'b0);
    for (int i = 0; i < 30; i++) step(i == 0, 1'b0, 8'hC0, 1'b0);
    chk("done_after_rst", 32'(done_at), 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 8'h80, 1'b0);
    measure_start();
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 8'h80, 1'b0);
    chk("done_lat_rel", 32'(done_at), 32'd19);
    s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) s = ~s;
      step($urandom_range(0, 299) == 0, s, 8'($urandom), 1'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_write_controller.md
# lcd_write_controller

Single-transfer write engine for an HD44780-compatible character LCD, such as the 16x2 module on the DE2-115. A host sequencer places one command or character byte plus a register-select bit on its inputs and pulses a start request. The block then generates the LCD enable strobe with fixed timing and reports completion. It sits between the message/LUT sequencer and the LCD pins. It performs no initialisation sequencing and no busy-flag polling.

## Interface
Parameters:
- CLK_DIVIDE, default 16: number of counter steps in the enable-high phase. Must be ≥ 2.

Ports:
- iCLK, input, 1: system clock. All state changes on the rising edge.
- iRST, input, 1: reset, synchronous, active-high.
- iDATA, input, 8: byte to write (command or character).
- iRS, input, 1: register select. 0 = command, 1 = data.
- iStart, input, 1: start request. Only a 0→1 transition is acted on.
- oDone, output, 1: completion flag. Registered and sticky.
- LCD_DATA, output, 8: LCD data bus. Combinational copy of iDATA.
- LCD_RW, output, 1: constant 0 (write-only).
- LCD_EN, output, 1: LCD enable strobe. Registered.
- LCD_RS, output, 1: combinational copy of iRS.

## Operation
- Edge detector: register preStart <= iStart every cycle. A start edge occurs in a cycle where iStart=1 and preStart=0.
- On a start edge, set the internal flag mStart=1 and clear oDone to 0.
- While mStart=1, run the state machine ST (2 bits):
  - ST0 (idle): go to ST1.
  - ST1: set LCD_EN=1, go to ST2.
  - ST2: if Cont < CLK_DIVIDE-1, increment Cont; otherwise go to ST3.
  - ST3: set LCD_EN=0, mStart=0, oDone=1, Cont=0, then go to ST0.
- When mStart=0, ST, Cont and LCD_EN hold their values.
- Cont width is the minimum needed for CLK_DIVIDE-1, and at least 5 bits.
- oDone stays 1 until the next start edge or reset.
- The host must hold iDATA and iRS stable from the start edge until oDone=1. The block does not latch them.
- Start edge while busy (mStart=1): the transfer is not restarted and timing is unaffected. oDone stays 0 (it is already 0).
- Host protocol: assert iStart, wait for oDone=1, deassert iStart. Deassertion has no effect on an in-flight transfer.
- Reset: oDone=0, LCD_EN=0, preStart=0, mStart=0, Cont=0, ST=ST0.
  - LCD_RW=0 at all times.
  - LCD_DATA and LCD_RS follow their inputs even during reset.
- Reset mid-transfer aborts it immediately: EN drops on the next edge and oDone=0.
- If iStart is already high when reset releases, this is treated as a start edge on the first post-reset cycle.

## Timing
Edge numbering: E0 is the clock edge at which the start edge is sampled (iStart=1, preStart=0).
- E0: mStart←1, oDone←0.
- E1: ST0→ST1.
- E2: LCD_EN←1.
- E3 … E(CLK_DIVIDE+1): Cont counts 1 … CLK_DIVIDE-1.
- E(CLK_DIVIDE+2): ST→ST3.
- E(CLK_DIVIDE+3): LCD_EN←0, oDone←1.
- LCD_EN is high for exactly CLK_DIVIDE+1 clock cycles (17 at the default).
- oDone rises CLK_DIVIDE+3 edges after E0 (19 at the default).
- The earliest next start edge can be sampled at E(CLK_DIVIDE+4), after iStart has been seen low.
- Back-to-back throughput: one byte per CLK_DIVIDE+5 cycles minimum, including the iStart low cycle.
- At 50 MHz the default gives a 340 ns EN pulse. The host sequencer adds the inter-command delay required by the LCD.

## Test plan
- Reset with iStart=0, then idle 50 cycles: LCD_EN=0, oDone=0, LCD_RW=0 throughout.
- iDATA=0x38, iRS=0, iStart 0→1 and held: LCD_DATA=0x38 and LCD_RS=0 immediately. LCD_EN is high for exactly 17 cycles starting 2 edges after E0. oDone=1 at E19 and stays high while iStart remains high.
- iDATA=0x57, iRS=1, start; after oDone, drop iStart and restart with iDATA=0x45: oDone clears at the new E0, and a second 17-cycle EN pulse follows.
- During a transfer, toggle iStart 1→0→1 at E5: the EN pulse is still 17 cycles and oDone still rises at the original E19.
- Assert iRST at E10 of a transfer: LCD_EN=0 and oDone=0 on the next edge, and no completion occurs afterwards.
- CLK_DIVIDE=4 build: EN high for 5 cycles, oDone at E7.
